exec_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer attached to the execute stage. Handles RV32M ops that the single-cycle ALU cannot.
- Accepts an operation from execute and stalls the pipeline while busy.
- Runs a radix-2 shift/add (multiply) or restoring shift/subtract (divide) loop, then returns a 32-bit result and destination register to the M-stage write path.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_datapath.sv | 134 +++++++++++++
 rtl/exec_muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_exec_muldiv_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/add multiplier and restoring divider registers, stepped by the sequencer FSM.
// Optional MULDIV_EARLY_OUT_EN exposes multiply early-termination flags.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  muldiv_op_e      i_op,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_prep,
    input  logic            i_step,
    output logic            o_div_special,
    output logic            o_mul_skip,
    output logic            o_mul_early,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN:0]     r_rem;
    logic              r_neg;

    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_is_div;
    logic [XLEN+1:0]   w_shift;
    logic [XLEN+1:0]   w_sub;
    logic              w_sub_ok;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_is_div   = is_div(i_op);
    assign w_neg_a    = is_signed_a(i_op) & r_a[XLEN-1];
    assign w_neg_b    = is_signed_b(i_op) & r_b[XLEN-1];
    assign w_abs_a    = w_neg_a ? -r_a : r_a;
    assign w_abs_b    = w_neg_b ? -r_b : r_b;
    assign w_div_zero = (r_b == '0);
    assign w_div_ovf  = is_signed_b(i_op) && (r_a == XLEN'(DIV_OVF_DIVIDEND)) && (r_b == '1);

    assign o_div_special = w_is_div && (w_div_zero || w_div_ovf);

`ifdef MULDIV_EARLY_OUT_EN
    assign o_mul_skip  = w_div_zero;
    assign o_mul_early = (r_mplier[XLEN-1:1] == '0);
`else
    assign o_mul_skip  = 1'b0;
    assign o_mul_early = 1'b0;
`endif

    // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_sub    = w_shift - {2'b00, r_div};
    assign w_sub_ok = ~w_sub[XLEN+1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (i_load) begin
                r_a <= i_src_a;
                r_b <= i_src_b;
            end
            if (i_prep) begin
                r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_prod   <= '0;
                r_div    <= w_abs_b;
                r_quo    <= w_abs_a;
                r_rem    <= '0;
                r_neg    <= (w_is_div && i_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
                if (w_is_div && w_div_zero) begin
                    r_quo <= '1;
                    r_rem <= {1'b0, r_a};
                    r_neg <= 1'b0;
                end else if (w_is_div && w_div_ovf) begin
                    r_quo <= XLEN'(DIV_OVF_DIVIDEND);
                    r_rem <= '0;
                    r_neg <= 1'b0;
                end
            end
            if (i_step) begin
                if (w_is_div) begin
                    r_rem <= w_sub_ok ? w_sub[XLEN:0] : w_shift[XLEN:0];
                    r_quo <= {r_quo[XLEN-2:0], w_sub_ok};
                end else begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end
            end
        end
    end

    assign w_prod_fix = r_neg ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

    // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        o_result = w_prod_fix[XLEN-1:0];
        case (i_op)
            OP_MUL:                        o_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  o_result = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               o_result = w_quo_fix;
            default:                       o_result = w_rem_fix;
        endcase
    end

endmodule

// File: rtl/exec_muldiv_ctrl.sv
// RV32M multi-cycle sequencer: FSM, iteration counter and pipeline stall for the execute stage.
// Optional MULDIV_EARLY_OUT_EN lets multiplies leave ITER once the multiplier is exhausted.
module exec_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] srcA_i,
    input  logic [XLEN-1:0] srcB_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    muldiv_state_e    r_state;
    muldiv_state_e    w_next;
    muldiv_op_e       r_op;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [XLEN-1:0]  r_result;
    logic [4:0]       r_rd_out;

    logic             w_idle;
    logic             w_accept;
    logic             w_prep;
    logic             w_step;
    logic             w_finish;
    logic             w_is_div;
    logic             w_div_special;
    logic             w_mul_skip;
    logic             w_mul_early;
    logic [XLEN-1:0]  w_result;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & start_i & ~flush_i;
    assign w_prep   = (r_state == ST_PREP);
    assign w_step   = (r_state == ST_ITER);
    assign w_finish = (r_state == ST_FIX) & ~flush_i;
    assign w_is_div = is_div(r_op);

    assign busy_o   = ~w_idle;
    assign stall_o  = busy_o | w_accept;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign rd_o     = r_rd_out;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_PREP;
            ST_PREP: begin
                if (flush_i)
                    w_next = ST_IDLE;
                else if (w_div_special || (!w_is_div && w_mul_skip))
                    w_next = ST_FIX;
                else
                    w_next = ST_ITER;
            end
            ST_ITER: begin
                if (flush_i)
                    w_next = ST_IDLE;
                else if ((r_cnt == '0) || (!w_is_div && w_mul_early))
                    w_next = ST_FIX;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_finish;
            if (w_accept) begin
                r_op <= muldiv_op_e'(op_i);
                r_rd <= rd_i;
            end
            if (w_prep) begin
                r_cnt <= CNT_W'(XLEN - 1);
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Flush in FIX drops the completion, so the visible result only moves on a real finish.
            if (w_finish) begin
                r_result <= w_result;
                r_rd_out <= r_rd;
            end
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .i_op          (r_op),
        .i_load        (w_accept),
        .i_src_a       (srcA_i),
        .i_src_b       (srcB_i),
        .i_prep        (w_prep),
        .i_step        (w_step),
        .o_div_special (w_div_special),
        .o_mul_skip    (w_mul_skip),
        .o_mul_early   (w_mul_early),
        .o_result      (w_result)
    );

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Directed scoreboard bench for exec_muldiv_ctrl; honours MULDIV_EARLY_OUT_EN for expected latency.
module tb_exec_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] srcA_i;
    logic [31:0] srcB_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass;
    int          n_checks;
    int          n_fail;
    logic [31:0] last_result;
    logic [4:0]  last_rd;
    bit          any_done;

    exec_muldiv_ctrl #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .srcA_i   (srcA_i),
        .srcB_i   (srcB_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        if (op[2]) begin
            if (b == 0) return 3;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
            return 35;
        end
        mag = (op == 3'd1 && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (mag == 0) return 3;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) return 3 + i + 1;
        end
`endif
        return (mag == 0) ? 35 : 35;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        srcA_i  = a;
        srcB_i  = b;
        rd_i    = rd;
        #1;
        check("stall_issue", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        srcA_i  = '0;
        srcB_i  = '0;
        rd_i    = '0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        int   lat;
        bit   stall_ok;
        bit   seen;
        e.result = model(op, a, b);
        e.rd     = rd;
        sb_q.push_back(e);
        issue(op, a, b, rd);
        lat      = 1;
        stall_ok = 1'b1;
        while (lat < 64 && !done_o) begin
            if (!stall_o || !busy_o) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        seen = done_o;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        e = sb_q.pop_front();
        if (seen) begin
            check({tag, "_latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
            check({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
            check({tag, "_stall_at_done"}, {31'd0, stall_o}, 32'd0);
            check({tag, "_result"}, result_o, e.result);
            check({tag, "_rd"}, {27'd0, rd_o}, {27'd0, e.rd});
            last_result = e.result;
            last_rd     = e.rd;
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
            check({tag, "_result_hold"}, result_o, e.result);
        end
    endtask

    initial begin
        n_pass      = 0;
        n_checks    = 0;
        n_fail      = 0;
        last_result = '0;
        last_rd     = '0;
        rst         = 1'b1;
        start_i     = 1'b0;
        flush_i     = 1'b0;
        op_i        = '0;
        srcA_i      = '0;
        srcB_i      = '0;
        rd_i        = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy_o},  32'd0);
        check("rst_done",   {31'd0, done_o},  32'd0);
        check("rst_stall",  {31'd0, stall_o}, 32'd0);
        check("rst_result", result_o,         32'd0);
        check("rst_rd",     {27'd0, rd_o},    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        run_op("mul_7x6",      OP_MUL,    32'd7,          32'd6,          5'd5);
        run_op("mulh_m1xm1",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6);
        run_op("mulhu_m1xm1",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7);
        run_op("mulhsu_m1x2",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd8);
        run_op("div_m7_2",     OP_DIV,    -32'sd7,        32'd2,          5'd9);
        run_op("rem_m7_2",     OP_REM,    -32'sd7,        32'd2,          5'd10);
        run_op("divu_100_7",   OP_DIVU,   32'd100,        32'd7,          5'd11);
        run_op("remu_100_7",   OP_REMU,   32'd100,        32'd7,          5'd12);
        run_op("div_5_0",      OP_DIV,    32'd5,          32'd0,          5'd13);
        run_op("rem_5_0",      OP_REM,    32'd5,          32'd0,          5'd14);
        run_op("divu_5_0",     OP_DIVU,   32'd5,          32'd0,          5'd15);
        run_op("div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd16);
        run_op("rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17);
        run_op("divu_big_m1",  OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd18);

        // Start together with flush must be dropped.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i    = OP_MUL;
        srcA_i  = 32'd3;
        srcB_i  = 32'd3;
        rd_i    = 5'd19;
        #1;
        check("startflush_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i  = 1'b0;
        flush_i  = 1'b0;
        check("startflush_busy", {31'd0, busy_o}, 32'd0);
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any_done |= done_o;
        end
        check("startflush_no_done", {31'd0, any_done}, 32'd0);

        // Flush in N+12 of an in-flight DIVU.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd20);
        any_done = 1'b0;
        repeat (11) begin
            @(negedge clk);
            any_done |= done_o;
        end
        check("flush_busy_before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy_after",  {31'd0, busy_o},  32'd0);
        check("flush_stall_after", {31'd0, stall_o}, 32'd0);
        check("flush_result_kept", result_o,         last_result);
        check("flush_rd_kept",     {27'd0, rd_o},    {27'd0, last_rd});
        repeat (40) begin
            @(negedge clk);
            any_done |= done_o;
        end
        check("flush_no_done", {31'd0, any_done}, 32'd0);

        run_op("after_flush_mul", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
        for (int k = 0; k < 6; k++) begin
            run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(1, 31)));
        end
        run_op("mulh_neg_small", OP_MULH, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 5'd22);
        run_op("mul_9x3", OP_MUL, 32'd9, 32'd3, 5'd23);
        run_op("mul_x0",  OP_MUL, 32'd77, 32'd0, 5'd24);

        // Asynchronous reset while the multiplier is still iterating.
        run_op("mul_pre_rst", OP_MUL, 32'd11, 32'd5, 5'd25);
        issue(OP_MUL, 32'h1234, 32'hFFFF, 5'd26);
        repeat (7) @(negedge clk);
        check("prerst_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy",   {31'd0, busy_o},  32'd0);
        check("midrst_done",   {31'd0, done_o},  32'd0);
        check("midrst_stall",  {31'd0, stall_o}, 32'd0);
        check("midrst_result", result_o,         32'd0);
        check("midrst_rd",     {27'd0, rd_o},    32'd0);
        @(negedge clk);
        rst      = 1'b0;
        any_done = 1'b0;
        repeat (45) begin
            @(negedge clk);
            any_done |= done_o;
        end
        check("midrst_no_done", {31'd0, any_done}, 32'd0);

        run_op("post_rst_remu", OP_REMU, 32'd100, 32'd7, 5'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
